// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: arbitrates read/write requesters onto the multiplexed RTC bus with timed address/data phases
module rtc_bus_sequencer #(
    parameter int T_PULSE = 10,
    parameter int T_GAP   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic       rd_ack,
    output logic [7:0] rd_data,
    output logic       busy,
    inout  wire  [7:0] datRTC,
    output logic       CS,
    output logic       AD,
    output logic       RD,
    output logic       WR
);
    localparam logic [7:0] PULSE = 8'(T_PULSE);
    localparam logic [7:0] GAP   = 8'(T_GAP);

    typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [7:0] addr_q, data_q, addr_nx, data_nx, dout, dout_nx;
    logic       last_wr, last_nx, pick_wr, grant, phase_end;
    logic       oe, oe_nx, cs_nx, ad_nx, rd_nx, wr_nx;

    assign datRTC = oe ? dout : 8'hzz;

    // arbitration, phase sequencing and next values of every registered pin
    always_comb begin
        pick_wr   = wr_req && (!rd_req || !last_wr);
        grant     = (state == IDLE) && (wr_req || rd_req);
        last_nx   = grant ? pick_wr : last_wr;
        addr_nx   = grant ? (pick_wr ? wr_addr : rd_addr) : addr_q;
        data_nx   = (grant && pick_wr) ? wr_data : data_q;
        phase_end = cnt == 8'd1;
        state_nx  = state;
        cnt_nx    = cnt - 8'd1;
        case (state)
            IDLE: begin
                state_nx = grant ? ADDR : IDLE;
                cnt_nx   = grant ? PULSE : 8'd0;
            end
            ADDR: if (phase_end) begin
                state_nx = GAP1;
                cnt_nx   = GAP;
            end
            GAP1: if (phase_end) begin
                state_nx = DATA;
                cnt_nx   = PULSE;
            end
            DATA: if (phase_end) begin
                state_nx = GAP2;
                cnt_nx   = GAP;
            end
            GAP2: if (phase_end) begin
                state_nx = DONE;
                cnt_nx   = 8'd1;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
        oe_nx   = (state_nx == ADDR) || (state_nx == DATA && last_nx);
        cs_nx   = !(state_nx == ADDR || state_nx == DATA);
        ad_nx   = state_nx != ADDR;
        wr_nx   = !oe_nx;
        rd_nx   = !(state_nx == DATA && !last_nx);
        dout_nx = (state_nx == ADDR) ? addr_nx : data_nx;
    end

    // state, latched request and pin registers; reset drops the bus and any transaction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            last_wr <= 1'b0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            dout    <= 8'h00;
            oe      <= 1'b0;
            CS      <= 1'b1;
            AD      <= 1'b1;
            RD      <= 1'b1;
            WR      <= 1'b1;
            busy    <= 1'b0;
            wr_ack  <= 1'b0;
            rd_ack  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            last_wr <= last_nx;
            addr_q  <= addr_nx;
            data_q  <= data_nx;
            dout    <= dout_nx;
            oe      <= oe_nx;
            CS      <= cs_nx;
            AD      <= ad_nx;
            RD      <= rd_nx;
            WR      <= wr_nx;
            busy    <= state_nx != IDLE;
            wr_ack  <= (state_nx == DONE) && last_nx;
            rd_ack  <= (state_nx == DONE) && !last_nx;
        end
    end

    // read byte is taken from the bus on the edge that closes the final read-strobe cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_data <= 8'h00;
        else if (state == DATA && phase_end && !last_wr)
            rd_data <= datRTC;
    end
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: self-checking bench with an RTC register model and a transaction scoreboard
module tb_rtc_bus_sequencer;
    localparam int TP = 4;
    localparam int TG = 2;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    logic       clk = 1'b0, reset = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
    logic [7:0] wr_addr = 8'h00, wr_data = 8'h00, rd_addr = 8'h00;
    logic       wr_ack, rd_ack, busy, CS, AD, RD, WR;
    logic [7:0] rd_data;
    wire  [7:0] datRTC;

    txn_t       q[$];
    txn_t       vec[7];
    txn_t       e;
    logic [7:0] mem[256];
    logic [7:0] m_addr = 8'h00, m_data = 8'h00;
    int         checks = 0, errors = 0, cyc = 0, n_addr = 0, n_data = 0, t_addr = 0, t_data = 0, idle_cnt = 0;
    bit         hold = 1'b0;

    rtc_bus_sequencer #(.T_PULSE(TP), .T_GAP(TG)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .busy(busy), .datRTC(datRTC), .CS(CS), .AD(AD), .RD(RD), .WR(WR)
    );

    always #5 clk = ~clk;

    // RTC model answers a read data phase with the addressed register
    assign datRTC = (!CS && AD && !RD) ? mem[m_addr] : 8'hzz;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // bus monitor: protocol rules every cycle, phase timing and scoreboard compare on each ack
    initial forever begin
        @(negedge clk);
        cyc++;
        chk("strobe_overlap", int'(!RD && !WR), 0);
        chk("strobe_without_cs", int'(CS && !(RD && WR)), 0);
        if (!reset) begin
            n_addr = 0;
            n_data = 0;
        end else begin
            if (!CS && !AD) begin
                if (n_addr == 0) t_addr = cyc;
                n_addr++;
                m_addr = datRTC;
            end
            if (!CS && AD) begin
                if (n_data == 0) t_data = cyc;
                n_data++;
                if (!WR) begin
                    m_data = datRTC;
                    mem[m_addr] = datRTC;
                end
            end
            if (wr_ack || rd_ack) begin
                if (q.size() == 0) chk("unexpected_ack", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("ack_dir", int'(wr_ack), int'(e.wr));
                    chk("ack_both", int'(wr_ack && rd_ack), 0);
                    chk("addr", int'(m_addr), int'(e.addr));
                    chk("data", int'(e.wr ? m_data : rd_data), int'(e.data));
                    chk("addr_cycles", n_addr, TP);
                    chk("data_cycles", n_data, TP);
                    chk("gap1_len", t_data - t_addr - TP, TG);
                    chk("ack_latency", cyc - t_addr + 1, 2 * (TP + TG) + 1);
                    chk("busy_at_ack", int'(busy), 1);
                end
                n_addr = 0;
                n_data = 0;
            end
        end
    end

    task automatic wait_done(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
            if (!busy) idle_cnt++;
            if (!hold) begin
                if (wr_ack) wr_req = 1'b0;
                if (rd_ack) rd_req = 1'b0;
            end
        end
        chk({nm, "_pending"}, q.size(), 0);
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h22] = 8'h59;
        vec[0] = '{1'b1, 8'h00, 8'hFF};
        vec[1] = '{1'b0, 8'h00, 8'hFF};
        vec[2] = '{1'b1, 8'hFF, 8'hA5};
        vec[3] = '{1'b0, 8'hFF, 8'hA5};
        vec[4] = '{1'b0, 8'h30, 8'h3C};
        vec[5] = '{1'b1, 8'h10, 8'h33};
        vec[6] = '{1'b0, 8'h10, 8'h33};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_pins", int'({CS, AD, RD, WR}), 4'hF);
        chk("rst_busy", int'(busy), 0);
        chk("rst_acks", int'({wr_ack, rd_ack}), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        reset = 1'b1;

        // read aborted by reset in its second address cycle, then restarted by the held request
        @(negedge clk);
        rd_addr = 8'h22;
        rd_req  = 1'b1;
        q.push_back('{1'b0, 8'h22, 8'h59});
        for (int i = 0; i < 20 && n_addr != 2; i++) begin
            @(negedge clk);
            #1;
        end
        chk("abort_point", n_addr, 2);
        reset = 1'b0;
        #1;
        chk("abort_pins", int'({CS, AD, RD, WR}), 4'hF);
        chk("abort_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        #1;
        chk("abort_no_ack", int'(wr_ack || rd_ack), 0);
        chk("abort_rd_data", int'(rd_data), 0);
        reset = 1'b1;
        wait_done("restart");

        // fresh reset, simultaneous requests: write first, one idle cycle, then read
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr_addr = 8'h21;
        wr_data = 8'h15;
        rd_addr = 8'h22;
        q.push_back('{1'b1, 8'h21, 8'h15});
        q.push_back('{1'b0, 8'h22, 8'h59});
        wr_req   = 1'b1;
        rd_req   = 1'b1;
        idle_cnt = 0;
        wait_done("both");
        chk("busy_gap", idle_cnt, 1);
        chk("reg21", int'(mem[8'h21]), 8'h15);
        chk("rd_data_first", int'(rd_data), 8'h59);

        // both held continuously: strict alternation W,R,W,R
        @(negedge clk);
        wr_addr = 8'h30;
        wr_data = 8'h3C;
        rd_addr = 8'h21;
        for (int i = 0; i < 2; i++) begin
            q.push_back('{1'b1, 8'h30, 8'h3C});
            q.push_back('{1'b0, 8'h21, 8'h15});
        end
        hold   = 1'b1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        wait_done("alternate");
        hold = 1'b0;

        // single transactions from the vector table
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (vec[i].wr) begin
                wr_addr = vec[i].addr;
                wr_data = vec[i].data;
                wr_req  = 1'b1;
            end else begin
                rd_addr = vec[i].addr;
                rd_req  = 1'b1;
            end
            q.push_back(vec[i]);
            wait_done("vec");
        end
        chk("rd_data_last", int'(rd_data), 8'h33);

        // one-cycle read pulse while a write is busy is ignored
        @(negedge clk);
        wr_addr = 8'h40;
        wr_data = 8'h77;
        wr_req  = 1'b1;
        q.push_back('{1'b1, 8'h40, 8'h77});
        repeat (3) @(negedge clk);
        rd_addr = 8'h22;
        rd_req  = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        wait_done("pulse");
        repeat (20) @(negedge clk);
        #1;
        chk("pulse_idle", int'(busy), 0);
        chk("reg40", int'(mem[8'h40]), 8'h77);
        chk("rd_data_held", int'(rd_data), 8'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
